axis_upsizer: RTL and testbench

AXI-Stream width upsizer. It sits directly downstream of the stream FIFO and packs RATIO narrow input beats into one wide output beat. Lane 0 is filled first (little-endian packing), and tkeep marks the valid lanes. A packet ending mid-word (tlast) flushes a partial word. The output is registered, with full input throughput.

---
 rtl/axis_pkg.sv | 13 +
 rtl/axis_upsizer_if.sv | 34 +++
 rtl/axis_upsizer.sv | 96 +++++++++
 tb/tb_axis_upsizer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared constants and helpers for the AXI-Stream width converters.
package axis_pkg;

    localparam int PKT_CNT_W = 16;

    // Lane index width; a single-lane converter still gets a 1-bit index.
    function automatic int lane_idx_w(input int ratio);
        int w;
        w = $clog2(ratio);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// Narrow input stream plus wide packed output stream of the upsizer.
// The slave modport is the converter's view; master is the surrounding logic.
interface axis_upsizer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
);
    localparam int OUT_WIDTH = DATA_WIDTH * RATIO;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tlast;
    logic                  s_axis_tready;

    logic [OUT_WIDTH-1:0]  m_axis_tdata;
    logic [RATIO-1:0]      m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        input  m_axis_tready
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid,
        output m_axis_tready
    );

endinterface

// File: rtl/axis_upsizer.sv
// Packs RATIO narrow beats little-endian into one wide word; tlast flushes a partial word.
// Latency: output valid 1 cycle after the completing input beat; full input throughput.
// Backpressure: input stalls only while a held output word is not being accepted.
module axis_upsizer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int RATIO      = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    axis_upsizer_if.slave        bus,
    output logic [PKT_CNT_W-1:0] pkt_count
);

    localparam int                OUT_WIDTH = DATA_WIDTH * RATIO;
    localparam int                LANE_W    = lane_idx_w(RATIO);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);

    logic [LANE_W-1:0]    idx_q,  idx_d;
    logic [OUT_WIDTH-1:0] data_q, data_d;
    logic [RATIO-1:0]     keep_q, keep_d;
    logic                 last_q, last_d;
    logic                 vld_q,  vld_d;
    logic [PKT_CNT_W-1:0] cnt_q,  cnt_d;

    logic s_rdy;
    logic in_acc;
    logic out_acc;
    logic word_done;

    // Input may load whenever the output register is empty or draining this cycle.
    assign s_rdy     = !areset && (!vld_q || bus.m_axis_tready);
    assign in_acc    = bus.s_axis_tvalid && s_rdy;
    assign out_acc   = vld_q && bus.m_axis_tready;
    assign word_done = in_acc && ((idx_q == LAST_LANE) || bus.s_axis_tlast);

    always_comb begin
        idx_d  = idx_q;
        data_d = data_q;
        keep_d = keep_q;
        last_d = last_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;

        if (out_acc) begin
            vld_d = 1'b0;
            if (last_q) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (in_acc) begin
            // Lane 0 starts a new word, so stale lanes from the previous word are wiped.
            if (idx_q == '0) begin
                data_d = '0;
                keep_d = '0;
            end
            data_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = bus.s_axis_tdata;
            keep_d[idx_q] = 1'b1;
            if (word_done) begin
                vld_d  = 1'b1;
                last_d = bus.s_axis_tlast;
                idx_d  = '0;
            end else begin
                idx_d  = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            idx_q  <= '0;
            data_q <= '0;
            keep_q <= '0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            data_q <= data_d;
            keep_q <= keep_d;
            last_q <= last_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.s_axis_tready = s_rdy;
    assign bus.m_axis_tdata  = data_q;
    assign bus.m_axis_tkeep  = keep_q;
    assign bus.m_axis_tlast  = last_q;
    assign bus.m_axis_tvalid = vld_q;
    assign pkt_count         = cnt_q;

endmodule

// File: tb/tb_axis_upsizer.sv
// Directed bench for axis_upsizer with DATA_WIDTH=8, RATIO=4.
module tb_axis_upsizer;

    logic        aclk;
    logic        areset;
    logic [15:0] pkt_count;

    int n_pass;
    int n_chk;

    axis_upsizer_if #(.DATA_WIDTH(8), .RATIO(4)) bus ();

    axis_upsizer #(.DATA_WIDTH(8), .RATIO(4)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .bus       (bus),
        .pkt_count (pkt_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        bus.s_axis_tvalid = v;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = l;
    endtask

    initial begin
        logic [31:0] exp_word;
        n_pass = 0;
        n_chk  = 0;
        areset = 1'b1;
        bus.m_axis_tready = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        // Reset and idle
        tick();
        tick();
        chk("rst_s_tready_low", 64'(bus.s_axis_tready), 64'd0);
        areset = 1'b0;
        #1;
        chk("idle_s_tready", 64'(bus.s_axis_tready), 64'd1);
        tick();
        chk("idle_m_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("idle_m_tdata",  64'(bus.m_axis_tdata),  64'd0);
        chk("idle_m_tkeep",  64'(bus.m_axis_tkeep),  64'd0);
        chk("idle_pkt_count", 64'(pkt_count), 64'd0);

        // Full 4-beat packet
        drive(1'b1, 8'h11, 1'b0); tick();
        drive(1'b1, 8'h22, 1'b0); tick();
        drive(1'b1, 8'h33, 1'b0); tick();
        chk("full_no_early_valid", 64'(bus.m_axis_tvalid), 64'd0);
        drive(1'b1, 8'h44, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("full_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        chk("full_tdata",  64'(bus.m_axis_tdata),  64'h44332211);
        chk("full_tkeep",  64'(bus.m_axis_tkeep),  64'hF);
        chk("full_tlast",  64'(bus.m_axis_tlast),  64'd1);
        tick();
        chk("full_drained", 64'(bus.m_axis_tvalid), 64'd0);
        chk("full_pkt_count", 64'(pkt_count), 64'd1);

        // Partial 2-beat packet, next packet starts in the acceptance cycle
        drive(1'b1, 8'hAA, 1'b0); tick();
        drive(1'b1, 8'hBB, 1'b1); tick();
        chk("part_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        chk("part_tdata",  64'(bus.m_axis_tdata),  64'h0000BBAA);
        chk("part_tkeep",  64'(bus.m_axis_tkeep),  64'h3);
        chk("part_tlast",  64'(bus.m_axis_tlast),  64'd1);
        drive(1'b1, 8'hCC, 1'b0);
        chk("part_overlap_s_tready", 64'(bus.s_axis_tready), 64'd1);
        tick();
        chk("next_lane0_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        chk("next_lane0_tdata",  64'(bus.m_axis_tdata),  64'h000000CC);
        chk("next_lane0_tkeep",  64'(bus.m_axis_tkeep),  64'h1);
        chk("part_pkt_count", 64'(pkt_count), 64'd2);
        drive(1'b1, 8'hDD, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("next_tdata", 64'(bus.m_axis_tdata), 64'h0000DDCC);
        chk("next_tkeep", 64'(bus.m_axis_tkeep), 64'h3);
        tick();
        chk("next_pkt_count", 64'(pkt_count), 64'd3);

        // Two words with a 3-cycle downstream stall on the first
        bus.m_axis_tready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0);
            tick();
        end
        drive(1'b1, 8'h05, 1'b0);
        for (int c = 0; c < 3; c++) begin
            chk("stall_s_tready", 64'(bus.s_axis_tready), 64'd0);
            chk("stall_tvalid",   64'(bus.m_axis_tvalid), 64'd1);
            chk("stall_tdata",    64'(bus.m_axis_tdata),  64'h04030201);
            chk("stall_tkeep",    64'(bus.m_axis_tkeep),  64'hF);
            chk("stall_tlast",    64'(bus.m_axis_tlast),  64'd0);
            tick();
        end
        bus.m_axis_tready = 1'b1;
        #1;
        chk("unstall_s_tready", 64'(bus.s_axis_tready), 64'd1);
        tick();
        chk("unstall_lane0", 64'(bus.m_axis_tdata), 64'h00000005);
        chk("unstall_keep",  64'(bus.m_axis_tkeep), 64'h1);
        chk("unstall_pkt_count", 64'(pkt_count), 64'd3);
        drive(1'b1, 8'h06, 1'b0); tick();
        drive(1'b1, 8'h07, 1'b0); tick();
        drive(1'b1, 8'h08, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("word1_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        chk("word1_tdata",  64'(bus.m_axis_tdata),  64'h08070605);
        chk("word1_tlast",  64'(bus.m_axis_tlast),  64'd1);
        tick();
        chk("word1_pkt_count", 64'(pkt_count), 64'd4);

        // Continuous 16-beat stream
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(8'h10 + i), (i == 15));
            chk("stream_s_tready", 64'(bus.s_axis_tready), 64'd1);
            tick();
            if (i % 4 == 3) begin
                exp_word = {8'(8'h10 + i), 8'(8'h0F + i), 8'(8'h0E + i), 8'(8'h0D + i)};
                chk("stream_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
                chk("stream_tdata",  64'(bus.m_axis_tdata),  64'(exp_word));
                chk("stream_tlast",  64'(bus.m_axis_tlast),  64'(i == 15));
            end else begin
                chk("stream_tvalid_gap", 64'(bus.m_axis_tvalid), 64'd0);
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        tick();
        chk("stream_pkt_count", 64'(pkt_count), 64'd5);

        // Reset in the middle of a packet
        drive(1'b1, 8'h66, 1'b0); tick();
        drive(1'b1, 8'h77, 1'b0); tick();
        drive(1'b0, 8'h00, 1'b0);
        areset = 1'b1;
        #1;
        chk("midrst_s_tready", 64'(bus.s_axis_tready), 64'd0);
        tick();
        areset = 1'b0;
        chk("midrst_tvalid",    64'(bus.m_axis_tvalid), 64'd0);
        chk("midrst_tdata",     64'(bus.m_axis_tdata),  64'd0);
        chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
        drive(1'b1, 8'h55, 1'b1); tick();
        drive(1'b0, 8'h00, 1'b0);
        chk("postrst_tvalid", 64'(bus.m_axis_tvalid), 64'd1);
        chk("postrst_tdata",  64'(bus.m_axis_tdata),  64'h00000055);
        chk("postrst_tkeep",  64'(bus.m_axis_tkeep),  64'h1);
        chk("postrst_tlast",  64'(bus.m_axis_tlast),  64'd1);
        tick();
        chk("postrst_pkt_count", 64'(pkt_count), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
